alu_instr_sequencer: RTL

Synchronous control sequencer that fetches an instruction through the MAR/MDR path and executes register–register ALU instructions on the datapath. It generates the enable strobes (register in/out, PC, MAR, MDR, IR, Y, ZLO, Read) and the ALU control code for fetch cycles T0–T2 and execute cycles T3–T5. It supports configurable register count, a memory-ready handshake and continuous-run mode. It sits between the top-level controller/bench and the datapath.

---
 rtl/alu_instr_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - fetch/execute control sequencer for register-register ALU instructions
module alu_instr_sequencer #(
    parameter int                NREG       = 16,
    parameter int                ALU_W      = 5,
    parameter logic [ALU_W-1:0]  INC_CODE   = 5'b11111,
    parameter logic [ALU_W-1:0]  MAX_ALU_OP = 5'b01100
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              run,
    input  logic              mem_rdy,
    input  logic [31:0]       ir,
    output logic [NREG-1:0]   reg_in,
    output logic [NREG-1:0]   reg_out,
    output logic              pout,
    output logic              pen,
    output logic              maren,
    output logic              read,
    output logic              mdren,
    output logic              mdrout,
    output logic              iren,
    output logic              yen,
    output logic              zloen,
    output logic              zloout,
    output logic [ALU_W-1:0]  alu_control,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5} state_t;

    localparam logic [4:0] NREG_L = 5'(NREG);

    state_t            state, state_nx;
    logic              t1_first;
    logic [ALU_W-1:0]  fld_op;
    logic [3:0]        fld_ra, fld_rb, fld_rc;
    logic [ALU_W-1:0]  alu_hold;
    logic              done_q, illegal_q;
    logic              bad;
    logic [NREG-1:0]   ra_oh, rb_oh, rc_oh;
    logic              unused_ir_bits;

    assign unused_ir_bits = ^ir[14:0];

    assign bad = (fld_op > MAX_ALU_OP) || ({1'b0, fld_ra} >= NREG_L) ||
                 ({1'b0, fld_rb} >= NREG_L) || ({1'b0, fld_rc} >= NREG_L);

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_T0;
            S_T0:    state_nx = S_T1;
            S_T1:    if (mem_rdy) state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            S_T3:    state_nx = bad ? S_IDLE : S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = run ? S_T0 : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Instruction fields are captured on the edge into T3 and stay stable for the execute phase.
    always_ff @(posedge clk) begin
        if (clr) begin
            t1_first  <= 1'b0;
            alu_hold  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            fld_op    <= '0;
            fld_ra    <= '0;
            fld_rb    <= '0;
            fld_rc    <= '0;
        end else begin
            t1_first <= (state == S_T0);
            done_q   <= (state == S_T5);
            if (state == S_T0)      alu_hold <= INC_CODE;
            else if (state == S_T4) alu_hold <= fld_op;
            if (state == S_IDLE && start)   illegal_q <= 1'b0;
            else if (state == S_T3 && bad)  illegal_q <= 1'b1;
            if (state == S_T2) begin
                fld_op <= ir[31 -: ALU_W];
                fld_ra <= ir[26:23];
                fld_rb <= ir[22:19];
                fld_rc <= ir[18:15];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            ra_oh[i] = (fld_ra == 4'(i));
            rb_oh[i] = (fld_rb == 4'(i));
            rc_oh[i] = (fld_rc == 4'(i));
        end
    end

    always_comb begin
        reg_in      = '0;
        reg_out     = '0;
        pout        = 1'b0;
        pen         = 1'b0;
        maren       = 1'b0;
        read        = 1'b0;
        mdren       = 1'b0;
        mdrout      = 1'b0;
        iren        = 1'b0;
        yen         = 1'b0;
        zloen       = 1'b0;
        zloout      = 1'b0;
        alu_control = alu_hold;
        busy        = (state != S_IDLE);
        done        = done_q;
        illegal     = illegal_q;
        case (state)
            S_T0: begin
                pout        = 1'b1;
                maren       = 1'b1;
                zloen       = 1'b1;
                alu_control = INC_CODE;
            end
            S_T1: begin
                read   = 1'b1;
                mdren  = 1'b1;
                pen    = t1_first;
                zloout = t1_first;
            end
            S_T2: begin
                mdrout = 1'b1;
                iren   = 1'b1;
            end
            S_T3: begin
                if (!bad) begin
                    reg_out = rb_oh;
                    yen     = 1'b1;
                end
            end
            S_T4: begin
                reg_out     = rc_oh;
                zloen       = 1'b1;
                alu_control = fld_op;
            end
            S_T5: begin
                reg_in = ra_oh;
                zloout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
